layer_sequencer: RTL and testbench
==================================

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameter MAX_LAYERS, default 8, maximum number of descriptor entries.
REQ-002 SHALL have parameter TIMEOUT, default 24'hFFFFFF, watchdog limit in cycles per layer.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-high (1 = reset).
REQ-005 SHALL have port cfg_wr_en  input  1  descriptor write strobe.
REQ-006 SHALL have port cfg_wr_idx  input  3  descriptor index written.
REQ-007 SHALL have port cfg_layer_type  input  LAYER_TYPE  layer type of the written descriptor.
REQ-008 SHALL have ports cfg_ifmap_addr, cfg_weight_addr and cfg_out_addr, each input `MEM_ADDR_SIZE, holding the descriptor base addresses.
REQ-009 SHALL have port num_layers  input  4  number of layers to run, sampled on start_net.
REQ-010 SHALL have port start_net  input  1  pulse that starts the sequence.
REQ-011 SHALL have port abort  input  1  pulse that abandons the sequence.
REQ-012 SHALL have port layer_complete  input  1  pulse from the accelerator top marking the end of a layer.
REQ-013 SHALL have port start_layer  output  1  one-cycle launch pulse to the accelerator top.
REQ-014 SHALL have port layer_type_out  output  LAYER_TYPE  drives layer_type_in of the accelerator top.
REQ-015 SHALL have ports ifmap_buffer_start_addr, weight_buffer_start_addr and compressor_start_addr, each output `MEM_ADDR_SIZE.
REQ-016 SHALL have ports busy  output 1, cur_layer  output 3, net_done  output 1 (pulse) and timeout_err  output 1 (sticky).

Function
REQ-017 SHALL implement a state machine with states IDLE, LAUNCH, RUN, GAP, DONE and ERR.
REQ-018 In IDLE, cfg_wr_en SHALL write entry cfg_wr_idx; indices >= MAX_LAYERS are ignored. In any other state, cfg_wr_en SHALL be ignored.
REQ-019 IDLE + start_net with 1 <= num_layers <= MAX_LAYERS: latch num_layers, set cur_layer=0, register entry 0 onto the descriptor outputs, go to LAUNCH.
REQ-020 In IDLE, start_net with num_layers of 0 or > MAX_LAYERS SHALL be ignored.
REQ-021 In states other than IDLE, start_net SHALL be ignored.
REQ-022 LAUNCH: start_layer=1 for exactly this cycle, watchdog cleared to 0, next state RUN.
REQ-023 Descriptor outputs SHALL be stable from LAUNCH through the end of RUN of that layer.
REQ-024 RUN: watchdog increments by 1 each cycle.
REQ-025 RUN + layer_complete on the last layer (cur_layer == num_layers-1) -> DONE.
REQ-026 RUN + layer_complete on any other layer -> cur_layer+1 and GAP.
REQ-027 RUN: watchdog == TIMEOUT-1 without layer_complete in that cycle -> ERR; if both occur in the same cycle, layer_complete wins.
REQ-028 GAP: register entry[cur_layer] onto the descriptor outputs, then go to LAUNCH; the next start_layer is therefore exactly 2 cycles after layer_complete.
REQ-029 DONE: net_done=1 for one cycle, then IDLE; cur_layer and the descriptor outputs hold their last values.
REQ-030 ERR: timeout_err=1, held; the block stays in ERR until abort or reset.
REQ-031 layer_complete outside RUN, including in the LAUNCH cycle, SHALL be ignored.
REQ-032 abort in any non-IDLE state SHALL cause IDLE next cycle, clear timeout_err and cur_layer, and issue no start_layer or net_done.
REQ-033 abort SHALL have priority over layer_complete and watchdog expiry.
REQ-034 busy SHALL be 1 in LAUNCH, RUN and GAP, and 0 otherwise.

Reset
REQ-035 While rst_n=1 at a clock edge: state IDLE; all outputs 0; all descriptor entries, watchdog and latched num_layers cleared.
REQ-036 Reset asserted mid-sequence SHALL abandon it with no further start_layer.

Verification
REQ-037 Write 3 entries (types A/B/C, ifmap 0x100/0x200/0x300), start_net num_layers=3, complete each layer 10 cycles after its start -> 3 start_layer pulses with matching addresses, each 2 cycles after the prior layer_complete; net_done 1 cycle after the 3rd layer_complete; busy then 0.
REQ-038 start_net with num_layers=0, then 9 -> no state change, start_layer never asserted.
REQ-039 TIMEOUT=16, no layer_complete -> ERR 16 cycles after LAUNCH, timeout_err=1 held; abort -> IDLE, timeout_err=0.
REQ-040 layer_complete on the same cycle watchdog hits TIMEOUT-1 -> layer advances, no ERR.
REQ-041 abort and layer_complete in the same RUN cycle -> IDLE, no GAP, no net_done.
REQ-042 cfg_wr_en to entry 1 during RUN, and start_net during RUN -> both ignored, entry 1 unchanged; layer_complete in the LAUNCH cycle -> ignored.

Source files
------------

// File: rtl/layer_sequencer.sv
// Network-level sequencer: holds a small table of layer descriptors and launches
// the accelerator once per layer, with a per-layer watchdog and abort.
`ifndef MEM_ADDR_SIZE
`define MEM_ADDR_SIZE 32
`endif
`ifndef LAYER_TYPE_W
`define LAYER_TYPE_W 2
`endif

module layer_sequencer #(
    parameter int          MAX_LAYERS = 8,
    parameter logic [23:0] TIMEOUT    = 24'hFFFFFF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_wr_en,
    input  logic [2:0]                cfg_wr_idx,
    input  logic [`LAYER_TYPE_W-1:0]  cfg_layer_type,
    input  logic [`MEM_ADDR_SIZE-1:0] cfg_ifmap_addr,
    input  logic [`MEM_ADDR_SIZE-1:0] cfg_weight_addr,
    input  logic [`MEM_ADDR_SIZE-1:0] cfg_out_addr,
    input  logic [3:0]                num_layers,
    input  logic                      start_net,
    input  logic                      abort,
    input  logic                      layer_complete,
    output logic                      start_layer,
    output logic [`LAYER_TYPE_W-1:0]  layer_type_out,
    output logic [`MEM_ADDR_SIZE-1:0] ifmap_buffer_start_addr,
    output logic [`MEM_ADDR_SIZE-1:0] weight_buffer_start_addr,
    output logic [`MEM_ADDR_SIZE-1:0] compressor_start_addr,
    output logic                      busy,
    output logic [2:0]                cur_layer,
    output logic                      net_done,
    output logic                      timeout_err
);

    localparam int AW     = `MEM_ADDR_SIZE;
    localparam int LTW    = `LAYER_TYPE_W;
    localparam int DESC_W = LTW + 3 * AW;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    logic [2:0]        state_reg;
    logic [2:0]        cur_layer_reg;
    logic [3:0]        num_layers_reg;
    logic [23:0]       watchdog_reg;
    logic [DESC_W-1:0] desc_reg;
    logic [DESC_W-1:0] cfg_desc;
    logic [DESC_W-1:0] entry_rd [8];
    logic              start_ok;
    logic              last_layer;

    assign cfg_desc   = {cfg_layer_type, cfg_ifmap_addr, cfg_weight_addr, cfg_out_addr};
    assign start_ok   = (num_layers != 4'd0) && (32'(num_layers) <= MAX_LAYERS);
    assign last_layer = ({1'b0, cur_layer_reg} == (num_layers_reg - 4'd1));

    // Descriptor table: entries beyond MAX_LAYERS exist but can never be written.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_entry
            logic [DESC_W-1:0] entry_reg;
            always_ff @(posedge clk) begin
                if (rst_n) begin
                    entry_reg <= '0;
                end else if (cfg_wr_en && (state_reg == S_IDLE) &&
                             (cfg_wr_idx == 3'(gi)) && (gi < MAX_LAYERS)) begin
                    entry_reg <= cfg_desc;
                end
            end
            assign entry_rd[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_reg      <= S_IDLE;
            cur_layer_reg  <= '0;
            num_layers_reg <= '0;
            watchdog_reg   <= '0;
            desc_reg       <= '0;
        end else if (abort && (state_reg != S_IDLE)) begin
            state_reg     <= S_IDLE;
            cur_layer_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start_net && start_ok) begin
                        num_layers_reg <= num_layers;
                        cur_layer_reg  <= '0;
                        desc_reg       <= entry_rd[0];
                        state_reg      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    watchdog_reg <= '0;
                    state_reg    <= S_RUN;
                end
                S_RUN: begin
                    watchdog_reg <= watchdog_reg + 24'd1;
                    // Completion wins over a watchdog expiry in the same cycle.
                    if (layer_complete) begin
                        if (last_layer) begin
                            state_reg <= S_DONE;
                        end else begin
                            cur_layer_reg <= cur_layer_reg + 3'd1;
                            state_reg     <= S_GAP;
                        end
                    end else if (watchdog_reg == (TIMEOUT - 24'd1)) begin
                        state_reg <= S_ERR;
                    end
                end
                S_GAP: begin
                    desc_reg  <= entry_rd[cur_layer_reg];
                    state_reg <= S_LAUNCH;
                end
                S_DONE:  state_reg <= S_IDLE;
                S_ERR:   state_reg <= S_ERR;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign start_layer = (state_reg == S_LAUNCH);
    assign busy        = (state_reg == S_LAUNCH) || (state_reg == S_RUN) || (state_reg == S_GAP);
    assign net_done    = (state_reg == S_DONE);
    assign timeout_err = (state_reg == S_ERR);
    assign cur_layer   = cur_layer_reg;
    assign {layer_type_out, ifmap_buffer_start_addr,
            weight_buffer_start_addr, compressor_start_addr} = desc_reg;

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: directed corner cases, a start-validity
// table and randomized networks checked against a transaction-level model.
`ifndef MEM_ADDR_SIZE
`define MEM_ADDR_SIZE 32
`endif
`ifndef LAYER_TYPE_W
`define LAYER_TYPE_W 2
`endif

module tb_layer_sequencer;

    localparam int AW     = `MEM_ADDR_SIZE;
    localparam int LTW    = `LAYER_TYPE_W;
    localparam int DESC_W = LTW + 3 * AW;
    localparam int TMO    = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              cfg_wr_en = 1'b0;
    logic [2:0]        cfg_wr_idx = '0;
    logic [LTW-1:0]    cfg_layer_type = '0;
    logic [AW-1:0]     cfg_ifmap_addr = '0;
    logic [AW-1:0]     cfg_weight_addr = '0;
    logic [AW-1:0]     cfg_out_addr = '0;
    logic [3:0]        num_layers = '0;
    logic              start_net = 1'b0;
    logic              abort = 1'b0;
    logic              layer_complete = 1'b0;
    logic              start_layer;
    logic [LTW-1:0]    layer_type_out;
    logic [AW-1:0]     ifmap_buffer_start_addr;
    logic [AW-1:0]     weight_buffer_start_addr;
    logic [AW-1:0]     compressor_start_addr;
    logic              busy;
    logic [2:0]        cur_layer;
    logic              net_done;
    logic              timeout_err;
    logic [DESC_W-1:0] dut_desc;

    int n_vec = 0;
    int n_err = 0;

    // Model of the descriptor table as the bench has programmed it.
    logic [DESC_W-1:0] m_desc [8];

    typedef struct {
        logic [3:0] nl;
        logic       exp_start;
    } vec_t;

    layer_sequencer #(.MAX_LAYERS(8), .TIMEOUT(24'd16)) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .cfg_wr_en                (cfg_wr_en),
        .cfg_wr_idx               (cfg_wr_idx),
        .cfg_layer_type           (cfg_layer_type),
        .cfg_ifmap_addr           (cfg_ifmap_addr),
        .cfg_weight_addr          (cfg_weight_addr),
        .cfg_out_addr             (cfg_out_addr),
        .num_layers               (num_layers),
        .start_net                (start_net),
        .abort                    (abort),
        .layer_complete           (layer_complete),
        .start_layer              (start_layer),
        .layer_type_out           (layer_type_out),
        .ifmap_buffer_start_addr  (ifmap_buffer_start_addr),
        .weight_buffer_start_addr (weight_buffer_start_addr),
        .compressor_start_addr    (compressor_start_addr),
        .busy                     (busy),
        .cur_layer                (cur_layer),
        .net_done                 (net_done),
        .timeout_err              (timeout_err)
    );

    assign dut_desc = {layer_type_out, ifmap_buffer_start_addr,
                       weight_buffer_start_addr, compressor_start_addr};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DESC_W-1:0] mk_desc(input int t, input logic [AW-1:0] a,
                                                  input logic [AW-1:0] b, input logic [AW-1:0] c);
        return {LTW'(t), a, b, c};
    endfunction

    task automatic write_desc(input int idx, input logic [DESC_W-1:0] d);
        {cfg_layer_type, cfg_ifmap_addr, cfg_weight_addr, cfg_out_addr} = d;
        cfg_wr_idx = 3'(idx);
        cfg_wr_en  = 1'b1;
        tick();
        cfg_wr_en  = 1'b0;
        m_desc[idx] = d;
    endtask

    // Runs one network from IDLE. dl[l] = RUN cycles that elapse before layer l
    // completes; a layer survives only if it completes within TMO RUN cycles.
    task automatic run_net(input int nl, input int dl [8]);
        int bad;
        num_layers = 4'(nl);
        start_net  = 1'b1;
        tick();
        start_net  = 1'b0;
        for (int l = 0; l < nl; l++) begin
            check("launch_pulse", 128'(start_layer), 128'(1));
            check("launch_desc", 128'(dut_desc), 128'(m_desc[l]));
            check("launch_cur", 128'(cur_layer), 128'(l));
            $display("layer %0d launched desc=%0h delay=%0d", l, dut_desc, dl[l]);
            bad = 0;
            tick();
            if (dl[l] < TMO) begin
                for (int k = 0; k < dl[l]; k++) begin
                    if (start_layer !== 1'b0 || busy !== 1'b1 || timeout_err !== 1'b0 ||
                        dut_desc !== m_desc[l]) bad++;
                    tick();
                end
                check("run_stable", 128'(bad), 128'(0));
                layer_complete = 1'b1;
                tick();
                layer_complete = 1'b0;
                if (l == nl - 1) begin
                    check("net_done", 128'(net_done), 128'(1));
                    check("done_busy", 128'(busy), 128'(0));
                    tick();
                    check("net_done_pulse", 128'(net_done), 128'(0));
                    check("idle_busy", 128'(busy), 128'(0));
                    check("final_cur", 128'(cur_layer), 128'(nl - 1));
                    check("final_desc", 128'(dut_desc), 128'(m_desc[l]));
                end else begin
                    check("gap_nolaunch", 128'(start_layer), 128'(0));
                    check("gap_cur", 128'(cur_layer), 128'(l + 1));
                    tick();
                end
            end else begin
                for (int k = 0; k < TMO - 1; k++) begin
                    if (start_layer !== 1'b0 || busy !== 1'b1 || timeout_err !== 1'b0 ||
                        dut_desc !== m_desc[l]) bad++;
                    tick();
                end
                check("run_stable", 128'(bad), 128'(0));
                check("pre_timeout", 128'(timeout_err), 128'(0));
                tick();
                check("timeout_err", 128'(timeout_err), 128'(1));
                check("err_busy", 128'(busy), 128'(0));
                repeat (3) tick();
                check("timeout_held", 128'(timeout_err), 128'(1));
                check("err_nolaunch", 128'(start_layer), 128'(0));
                abort = 1'b1;
                tick();
                abort = 1'b0;
                check("abort_clear", 128'(timeout_err), 128'(0));
                check("abort_cur", 128'(cur_layer), 128'(0));
                check("abort_busy", 128'(busy), 128'(0));
                $display("layer %0d timed out, aborted", l);
                return;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global time limit reached");
    end

    initial begin
        vec_t vecs [6];
        int   dl [8];
        int   cnt;

        for (int i = 0; i < 8; i++) m_desc[i] = '0;

        // Reset state
        tick();
        tick();
        check("rst_start", 128'(start_layer), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(net_done), 128'(0));
        check("rst_err", 128'(timeout_err), 128'(0));
        check("rst_cur", 128'(cur_layer), 128'(0));
        check("rst_desc", 128'(dut_desc), 128'(0));
        rst_n = 1'b0;
        tick();

        // Three-layer network, each layer completing 10 cycles after its launch
        write_desc(0, mk_desc(0, 32'h100, 32'h1000, 32'h2000));
        write_desc(1, mk_desc(1, 32'h200, 32'h1100, 32'h2100));
        write_desc(2, mk_desc(2, 32'h300, 32'h1200, 32'h2200));
        dl = '{9, 9, 9, 0, 0, 0, 0, 0};
        run_net(3, dl);

        // Start validity table
        vecs = '{'{4'd0, 1'b0}, '{4'd9, 1'b0}, '{4'd1, 1'b1},
                 '{4'd8, 1'b1}, '{4'd15, 1'b0}, '{4'd3, 1'b1}};
        for (int v = 0; v < 6; v++) begin
            num_layers = vecs[v].nl;
            start_net  = 1'b1;
            tick();
            start_net  = 1'b0;
            check("tbl_start", 128'(start_layer), 128'(vecs[v].exp_start));
            check("tbl_busy", 128'(busy), 128'(vecs[v].exp_start));
            $display("vector %0d: num_layers=%0d start_layer=%0b", v, vecs[v].nl, start_layer);
            if (vecs[v].exp_start) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                check("tbl_abort_busy", 128'(busy), 128'(0));
            end else begin
                tick();
                check("tbl_still_idle", 128'(busy | start_layer), 128'(0));
            end
        end

        // Watchdog expiry, then completion exactly at the watchdog limit
        dl = '{20, 0, 0, 0, 0, 0, 0, 0};
        run_net(1, dl);
        dl = '{TMO - 1, 0, 0, 0, 0, 0, 0, 0};
        run_net(2, dl);

        // abort and layer_complete in the same RUN cycle
        num_layers = 4'd2;
        start_net  = 1'b1;
        tick();
        start_net  = 1'b0;
        tick();
        abort = 1'b1;
        layer_complete = 1'b1;
        tick();
        abort = 1'b0;
        layer_complete = 1'b0;
        check("ab_lc_busy", 128'(busy), 128'(0));
        check("ab_lc_cur", 128'(cur_layer), 128'(0));
        check("ab_lc_done", 128'(net_done), 128'(0));
        tick();
        check("ab_lc_nolaunch", 128'(start_layer | busy), 128'(0));
        $display("abort+complete sequence done");

        // Complete during LAUNCH, config write and start_net during RUN
        num_layers = 4'd2;
        start_net  = 1'b1;
        tick();
        start_net  = 1'b0;
        layer_complete = 1'b1;
        tick();
        layer_complete = 1'b0;
        check("launch_lc_ignored", 128'(busy), 128'(1));
        check("launch_lc_cur", 128'(cur_layer), 128'(0));
        {cfg_layer_type, cfg_ifmap_addr, cfg_weight_addr, cfg_out_addr} =
            mk_desc(3, 32'hDEAD, 32'hBEEF, 32'hCAFE);
        cfg_wr_idx = 3'd1;
        cfg_wr_en  = 1'b1;
        num_layers = 4'd1;
        start_net  = 1'b1;
        tick();
        cfg_wr_en  = 1'b0;
        start_net  = 1'b0;
        layer_complete = 1'b1;
        tick();
        layer_complete = 1'b0;
        check("run_cfg_gap_cur", 128'(cur_layer), 128'(1));
        tick();
        check("run_cfg_launch", 128'(start_layer), 128'(1));
        check("run_cfg_entry1", 128'(dut_desc), 128'(m_desc[1]));
        tick();
        layer_complete = 1'b1;
        tick();
        layer_complete = 1'b0;
        check("run_start_ignored", 128'(net_done), 128'(1));
        tick();
        $display("ignored-input sequence done");

        // Reset mid-sequence abandons the network and clears the table
        num_layers = 4'd2;
        start_net  = 1'b1;
        tick();
        start_net  = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_cur", 128'(cur_layer), 128'(0));
        check("midrst_desc", 128'(dut_desc), 128'(0));
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (start_layer) cnt++;
            tick();
        end
        check("midrst_nolaunch", 128'(cnt), 128'(0));
        for (int i = 0; i < 8; i++) m_desc[i] = '0;
        dl = '{2, 0, 0, 0, 0, 0, 0, 0};
        run_net(1, dl);
        $display("mid-sequence reset done");

        // Randomized networks
        for (int n = 0; n < 25; n++) begin
            int nw;
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++)
                write_desc($urandom_range(0, 7),
                           mk_desc($urandom, AW'($urandom), AW'($urandom), AW'($urandom)));
            for (int i = 0; i < 8; i++) dl[i] = $urandom_range(0, TMO + 3);
            $display("random net %0d", n);
            run_net($urandom_range(1, 8), dl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
